stream_test_src: RTL

STREAM_TEST_SRC -- requirements
Module: stream_test_src

---
 rtl/stream_test_src.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stream_test_src.sv
// stream_test_src: stream bridge test source.
// Emits loopback, counting, constant or idle sample streams framed by a
// periodic sync pulse. Mode changes are deferred to frame boundaries unless
// the stream is idle.
// Optional feature: define STREAM_CHK_EN to build the loopback sequence
// checker that drives err_cnt; without it err_cnt is tied to zero.
module stream_test_src #(
  parameter int unsigned CH    = 2,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAME = 1024
) (
  input  logic             Sclk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    pattern,
  input  logic             Oen,
  input  logic [CH*DW-1:0] Sout,
  output logic [CH*DW-1:0] Sin,
  output logic             Ien,
  output logic             sync,
  output logic [1:0]       mode_act,
  output logic [15:0]      err_cnt
);

  localparam int unsigned FW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [1:0] M_LOOP  = 2'd0;
  localparam logic [1:0] M_COUNT = 2'd1;
  localparam logic [1:0] M_CONST = 2'd2;
  localparam logic [1:0] M_OFF   = 2'd3;

  typedef enum logic {RUN, PEND} state_t;

  state_t           st;
  logic [FW-1:0]    fcnt;
  logic [DW-1:0]    cnt [CH];

  logic             beat_c;
  logic [CH*DW-1:0] data_c;
  logic             last_c;
  logic             now_c;
  logic             apply_c;

  // Beat that the currently applied mode emits on the next edge
  always_comb begin
    beat_c = 1'b0;
    data_c = Sin;
    case (mode_act)
      M_LOOP: begin
        beat_c = Oen;
        if (Oen) data_c = Sout;
      end
      M_COUNT: begin
        beat_c = 1'b1;
        for (int k = 0; k < CH; k++) data_c[k*DW +: DW] = cnt[k];
      end
      M_CONST: begin
        beat_c = 1'b1;
        for (int k = 0; k < CH; k++) data_c[k*DW +: DW] = pattern;
      end
      default: begin
        beat_c = 1'b0;
      end
    endcase
  end

  // Mode apply: immediately when idle, otherwise on the last beat of a frame
  assign last_c  = beat_c && (fcnt == FW'(FRAME - 1));
  assign now_c   = (mode != mode_act) &&
                   ((mode_act == M_OFF) ||
                    ((mode_act == M_LOOP) && !Oen && (fcnt == '0)));
  assign apply_c = now_c || ((st == PEND) && last_c);

  // Stream outputs, frame/channel counters and mode-switch state machine
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= RUN;
      mode_act <= M_OFF;
      fcnt     <= '0;
      Sin      <= '0;
      Ien      <= 1'b0;
      sync     <= 1'b0;
      for (int k = 0; k < CH; k++) cnt[k] <= '0;
    end else begin
      Ien  <= beat_c;
      sync <= beat_c && (fcnt == '0);
      if (beat_c) Sin <= data_c;
      if (apply_c) begin
        mode_act <= mode;
        st       <= RUN;
        fcnt     <= '0;
        for (int k = 0; k < CH; k++) cnt[k] <= '0;
      end else begin
        if (beat_c) fcnt <= last_c ? '0 : fcnt + FW'(1);
        if (mode_act == M_COUNT) begin
          for (int k = 0; k < CH; k++)
            cnt[k] <= ((k % 2) == 0) ? cnt[k] + DW'(1) : cnt[k] - DW'(1);
        end
        if ((st == RUN) && (mode != mode_act)) st <= PEND;
      end
    end
  end

`ifdef STREAM_CHK_EN
  logic [DW-1:0] prev;
  logic          have_prev;

  // Loopback checker: channel 0 must step by +1 between consecutive Oen beats
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
      err_cnt   <= '0;
    end else if (apply_c) begin
      have_prev <= 1'b0;
    end else if ((mode_act == M_COUNT) && Oen) begin
      have_prev <= 1'b1;
      prev      <= Sout[DW-1:0];
      if (have_prev && (Sout[DW-1:0] != prev + DW'(1)) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = 16'd0;
`endif

endmodule
